fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID stage. It holds the PC, reads a word-addressed instruction memory, and drives the IF/ID pipeline register consumed by ID. It applies stall, flush and branch/jump redirects from the hazard and ID logic, and counts retired fetches for debug.

Parameters:
IM_DEPTH, 128, number of 32-bit instruction words; power of two.
PC_RESET, 32'h00000000, PC value after reset.
NOP_WORD, 32'h00000020, NOP encoding (add $0,$0,$0) injected on flush, redirect and reset.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
stall_i  input  1  hold PC and IF/ID (load-use hazard from hazard unit)
flush_i  input  1  squash the IF/ID contents to NOP
branch_taken_i  input  1  taken branch resolved in ID
branch_target_i  input  32  absolute byte address of branch target
jump_i  input  1  j instruction decoded in ID
jump_index_i  input  26  instr_index field of the j instruction
im_we  input  1  instruction-memory load strobe
im_waddr  input  32  word index for the load
im_wdata  input  32  instruction word to load
pc_o  output  32  current fetch PC (byte address)
fd_pc  output  32  byte address of the instruction in fd_instr
fd_pc4  output  32  fd_pc + 4
fd_instr  output  32  instruction presented to ID
fd_valid  output  1  fd_instr is a real fetched instruction
fetch_count  output  32  number of valid instructions loaded into IF/ID

Behaviour:
- Reset (rst low, asynchronous): pc_o=PC_RESET, fd_pc=0, fd_pc4=0, fd_instr=NOP_WORD, fd_valid=0, fetch_count=0. Instruction memory is not cleared.
- Fetch read is combinational: word = IM[pc_o[log2(IM_DEPTH)+1:2]] when pc_o[31:2] < IM_DEPTH. Otherwise word = NOP_WORD.
- pc_plus4 = pc_o + 4. This is 32-bit modular, so 32'hFFFFFFFC wraps to 0.
- Next-PC priority, highest first:
  - jump_i: {pc_plus4[31:28], jump_index_i, 2'b00}.
  - branch_taken_i: {branch_target_i[31:2], 2'b00}. Misaligned low bits are forced to 0.
  - stall_i: hold pc_o.
  - otherwise: pc_plus4.
- Redirect = jump_i | branch_taken_i. A redirect overrides stall_i in the same cycle.
- IF/ID update, each rising edge, highest priority first:
  - flush_i or redirect: fd_instr=NOP_WORD, fd_valid=0. fd_pc and fd_pc4 take pc_o and pc_plus4 for debug.
  - stall_i: all IF/ID fields hold.
  - otherwise: fd_instr=fetched word, fd_pc=pc_o, fd_pc4=pc_plus4, fd_valid=1.
- A flush together with a stall and no redirect squashes IF/ID and holds the PC.
- Latency: an instruction at address A appears on fd_instr one cycle after pc_o==A, given no stall or flush.
- fetch_count increments by 1 on each edge that sets fd_valid=1 by loading a new word. It holds on stall, flush and redirect, and wraps at 2^32.
- IM load: synchronous write on a rising edge when im_we=1 and im_waddr < IM_DEPTH. Out-of-range writes are ignored.
- Writing the word currently being fetched: that cycle's fetch returns the old contents, and the new word is visible from the next cycle.
- Reset asserted mid-operation forces the reset values immediately, regardless of clk. The first fetch after deassertion is at PC_RESET.

Test Plan:
- Straight-line run: load IM[0..4] = add $3,$1,$2 plus four NOP_WORD, then release rst. Required: fd_instr=32'h00221820 with fd_pc=0 and fd_valid=1 one cycle after release, then pc_o steps 4, 8, 12, and fetch_count=5 after 5 cycles.
- Stall: assert stall_i for 2 cycles while pc_o=8. Required: pc_o stays 8, fd_instr/fd_pc hold at the word from address 4, fetch_count does not increment, and fetch resumes at 8 afterwards.
- Branch redirect: with pc_o=12, pulse branch_taken_i with branch_target_i=32'h00000026. Required: next pc_o=32'h24, IF/ID=NOP_WORD with fd_valid=0, and the following cycle fetches IM[9].
- Jump with simultaneous stall: with pc_o=32'h10, assert jump_i with jump_index_i=15 and stall_i=1. Required: next pc_o=32'h3C, and IF/ID is squashed (not held).
- Out-of-range and wrap: with IM_DEPTH=128, branch to 32'h200. Required: fd_instr=NOP_WORD with fd_valid=1. Branch to 32'hFFFFFFFC. Required: the next PC is 0.
- Asynchronous reset: drive rst low between clock edges mid-run. Required: pc_o=0, fd_valid=0 and fetch_count=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a 5-stage MIPS pipeline. It holds the PC and reads
// a word-addressed instruction memory combinationally. It drives the IF/ID
// pipeline register consumed by the ID stage. Stall, flush and branch/jump
// redirects are applied here, and fetch_count counts the real instructions
// loaded into IF/ID for debug.
//
// Parameters
//   IM_DEPTH  number of 32-bit instruction words (power of two)
//   PC_RESET  PC value after reset
//   NOP_WORD  encoding injected into IF/ID on reset, flush and redirect
//
// Ports
//   clk              pipeline clock, rising edge
//   rst              asynchronous, active-low reset
//   stall_i          hold PC and IF/ID (load-use hazard)
//   flush_i          squash IF/ID to NOP
//   branch_taken_i   taken branch resolved in ID
//   branch_target_i  absolute byte address of the branch target
//   jump_i           j instruction decoded in ID
//   jump_index_i     instr_index field of the j instruction
//   im_we            instruction-memory load strobe
//   im_waddr         word index for the load
//   im_wdata         instruction word to load
//   pc_o             current fetch PC (byte address)
//   fd_pc            byte address of the instruction in fd_instr
//   fd_pc4           fd_pc + 4
//   fd_instr         instruction presented to ID
//   fd_valid         fd_instr is a real fetched instruction
//   fetch_count      number of valid instructions loaded into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int          IM_DEPTH = 128,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        im_we,
  input  logic [31:0] im_waddr,
  input  logic [31:0] im_wdata,
  output logic [31:0] pc_o,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_pc4,
  output logic [31:0] fd_instr,
  output logic        fd_valid,
  output logic [31:0] fetch_count
);

  localparam int AW = $clog2(IM_DEPTH);

  logic [31:0] im [IM_DEPTH];

  logic [31:0] pc_plus4;
  logic [31:0] pc_word;
  logic        fetch_in_range;
  logic [31:0] fetch_word;
  logic        redirect;
  logic [31:0] pc_next;

  // ---------------------------------------------------------------------------
  // Instruction memory
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset branch; clearing it would turn the
  // RAM into a huge flop bank, and the loaded program must survive a reset.
  // Out-of-range word indices are dropped so they cannot alias onto low words.
  always_ff @(posedge clk) begin
    if (im_we && (im_waddr < 32'(IM_DEPTH))) begin
      im[im_waddr[AW-1:0]] <= im_wdata;
    end
  end

  // Combinational fetch. A same-cycle write to this word is not visible until
  // the next cycle because the array itself only updates on the edge.
  assign pc_word        = {2'b00, pc_o[31:2]};
  assign fetch_in_range = (pc_word < 32'(IM_DEPTH));
  assign fetch_word     = fetch_in_range ? im[pc_o[AW+1:2]] : NOP_WORD;

  // ---------------------------------------------------------------------------
  // Next-PC selection: jump > branch > stall > sequential
  // ---------------------------------------------------------------------------
  assign pc_plus4 = pc_o + 32'd4;
  assign redirect = jump_i | branch_taken_i;

  // NOTE: every path assigns pc_next, so this block cannot infer a latch.
  always_comb begin
    pc_next = pc_plus4;
    if (jump_i) begin
      pc_next = {pc_plus4[31:28], jump_index_i, 2'b00};
    end else if (branch_taken_i) begin
      pc_next = {branch_target_i[31:2], 2'b00};
    end else if (stall_i) begin
      pc_next = pc_o;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o <= PC_RESET;
    end else begin
      pc_o <= pc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register and fetch counter
  // ---------------------------------------------------------------------------
  // A squash still records the PC that was being fetched, which helps when
  // tracing bubbles in a waveform.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fd_pc       <= 32'd0;
      fd_pc4      <= 32'd0;
      fd_instr    <= NOP_WORD;
      fd_valid    <= 1'b0;
      fetch_count <= 32'd0;
    end else if (flush_i || redirect) begin
      fd_pc    <= pc_o;
      fd_pc4   <= pc_plus4;
      fd_instr <= NOP_WORD;
      fd_valid <= 1'b0;
    end else if (!stall_i) begin
      fd_pc       <= pc_o;
      fd_pc4      <= pc_plus4;
      fd_instr    <= fetch_word;
      fd_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage. It loads the instruction memory during
// reset and then walks through straight-line fetch, stall, branch, jump with
// stall, flush with stall, out-of-range fetch, PC wrap, write-during-fetch and
// asynchronous reset. All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0020;
  localparam logic [31:0] ADD = 32'h0022_1820;  // add $3,$1,$2
  localparam logic [31:0] ADD2 = 32'h0043_2020; // add $4,$2,$3

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [25:0] jump_index_i;
  logic        im_we;
  logic [31:0] im_waddr;
  logic [31:0] im_wdata;
  logic [31:0] pc_o;
  logic [31:0] fd_pc;
  logic [31:0] fd_pc4;
  logic [31:0] fd_instr;
  logic        fd_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .IM_DEPTH(128),
    .PC_RESET(32'h0000_0000),
    .NOP_WORD(NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .jump_i         (jump_i),
    .jump_index_i   (jump_index_i),
    .im_we          (im_we),
    .im_waddr       (im_waddr),
    .im_wdata       (im_wdata),
    .pc_o           (pc_o),
    .fd_pc          (fd_pc),
    .fd_pc4         (fd_pc4),
    .fd_instr       (fd_instr),
    .fd_valid       (fd_valid),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fd(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                          input logic e_valid, input logic [31:0] e_cnt, input logic [31:0] e_fdpc);
    check({tag, " pc_o"}, pc_o, e_pc);
    check({tag, " fd_instr"}, fd_instr, e_instr);
    check({tag, " fd_valid"}, {31'd0, fd_valid}, {31'd0, e_valid});
    check({tag, " fetch_count"}, fetch_count, e_cnt);
    check({tag, " fd_pc"}, fd_pc, e_fdpc);
  endtask

  initial begin
    rst             = 1'b0;
    stall_i         = 1'b0;
    flush_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'd0;
    jump_i          = 1'b0;
    jump_index_i    = 26'd0;
    im_we           = 1'b0;
    im_waddr        = 32'd0;
    im_wdata        = 32'd0;

    // Load program while reset is held: word i = 0x2000_0000 + i, except
    // word 0 = add and words 1..4 = NOP.
    for (int i = 0; i < 128; i++) begin
      im_we    = 1'b1;
      im_waddr = i;
      if (i == 0)      im_wdata = ADD;
      else if (i <= 4) im_wdata = NOP;
      else             im_wdata = 32'h2000_0000 + i;
      cyc();
    end
    im_we = 1'b0;

    check_fd("reset", 32'h0, NOP, 1'b0, 32'd0, 32'h0);
    check("reset fd_pc4", fd_pc4, 32'h0);

    // Straight-line run
    rst = 1'b1;
    cyc();
    check_fd("run1", 32'h4, ADD, 1'b1, 32'd1, 32'h0);
    check("run1 fd_pc4", fd_pc4, 32'h4);
    cyc();
    check("run2 pc_o", pc_o, 32'h8);
    cyc();
    check("run3 pc_o", pc_o, 32'hC);
    cyc();
    cyc();
    check_fd("run5", 32'h14, NOP, 1'b1, 32'd5, 32'h10);

    // Re-enter address 4, then stall with pc_o = 8
    branch_taken_i = 1'b1; branch_target_i = 32'h4;
    cyc();
    branch_taken_i = 1'b0;
    check_fd("br4", 32'h4, NOP, 1'b0, 32'd5, 32'h14);
    cyc();
    check_fd("pre_stall", 32'h8, NOP, 1'b1, 32'd6, 32'h4);
    stall_i = 1'b1;
    cyc();
    check_fd("stall1", 32'h8, NOP, 1'b1, 32'd6, 32'h4);
    cyc();
    check_fd("stall2", 32'h8, NOP, 1'b1, 32'd6, 32'h4);
    stall_i = 1'b0;
    cyc();
    check_fd("resume", 32'hC, NOP, 1'b1, 32'd7, 32'h8);

    // Misaligned branch target from pc_o = 12
    branch_taken_i = 1'b1; branch_target_i = 32'h26;
    cyc();
    branch_taken_i = 1'b0;
    check_fd("br26", 32'h24, NOP, 1'b0, 32'd7, 32'hC);
    cyc();
    check_fd("br26_next", 32'h28, 32'h2000_0009, 1'b1, 32'd8, 32'h24);
    check("br26_next fd_pc4", fd_pc4, 32'h28);

    // Jump with simultaneous stall from pc_o = 0x10
    branch_taken_i = 1'b1; branch_target_i = 32'h10;
    cyc();
    branch_taken_i = 1'b0;
    check("to10 pc_o", pc_o, 32'h10);
    jump_i = 1'b1; jump_index_i = 26'd15; stall_i = 1'b1;
    cyc();
    jump_i = 1'b0; stall_i = 1'b0;
    check_fd("jmp_stall", 32'h3C, NOP, 1'b0, 32'd8, 32'h10);
    check("jmp_stall fd_pc4", fd_pc4, 32'h14);
    cyc();
    check_fd("jmp_next", 32'h40, 32'h2000_000F, 1'b1, 32'd9, 32'h3C);

    // Flush with stall, no redirect: squash IF/ID, hold PC
    flush_i = 1'b1; stall_i = 1'b1;
    cyc();
    flush_i = 1'b0; stall_i = 1'b0;
    check_fd("flush_stall", 32'h40, NOP, 1'b0, 32'd9, 32'h40);
    cyc();
    check_fd("flush_next", 32'h44, 32'h2000_0010, 1'b1, 32'd10, 32'h40);

    // Out-of-range fetch
    branch_taken_i = 1'b1; branch_target_i = 32'h200;
    cyc();
    branch_taken_i = 1'b0;
    check("to200 pc_o", pc_o, 32'h200);
    cyc();
    check_fd("oor", 32'h204, NOP, 1'b1, 32'd11, 32'h200);

    // PC wrap
    branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    cyc();
    branch_taken_i = 1'b0;
    check("toFFC pc_o", pc_o, 32'hFFFF_FFFC);
    cyc();
    check_fd("wrap", 32'h0, NOP, 1'b1, 32'd12, 32'hFFFF_FFFC);
    check("wrap fd_pc4", fd_pc4, 32'h0);

    // Write the word being fetched: old value is fetched this cycle
    im_we = 1'b1; im_waddr = 32'd0; im_wdata = ADD2;
    cyc();
    check_fd("wr_same", 32'h4, ADD, 1'b1, 32'd13, 32'h0);
    // Out-of-range write must not alias onto word 0
    im_waddr = 32'd128; im_wdata = 32'hDEAD_BEEF;
    branch_taken_i = 1'b1; branch_target_i = 32'h0;
    cyc();
    im_we = 1'b0; branch_taken_i = 1'b0;
    cyc();
    check_fd("wr_new", 32'h4, ADD2, 1'b1, 32'd14, 32'h0);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check_fd("async_rst", 32'h0, NOP, 1'b0, 32'd0, 32'h0);
    #1;
    rst = 1'b1;
    cyc();
    check_fd("post_rst", 32'h4, ADD2, 1'b1, 32'd1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
